// File: rtl/mul_result_acc.sv
// Result accumulator behind the 4-bit multiplier: sums BURST_LEN products and holds the total until taken.
// Build option: define MUL_ACC_SAT_EN for a saturating accumulator (default wraps modulo 2^ACC_W).
module mul_result_acc #(
  parameter int PROD_W    = 8,
  parameter int ACC_W     = 10,
  parameter int BURST_LEN = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_y,
  input  logic              clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf,
  output logic              busy
);

  localparam int CNT_W = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  typedef enum logic [0:0] {ACC, HOLD} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] acc_nxt;
  logic             carry;
  logic             accept;
  logic             last;

  always_comb begin
    sum_ext = {1'b0, acc} + (ACC_W+1)'(in_y);
    carry   = sum_ext[ACC_W];
`ifdef MUL_ACC_SAT_EN
    // Once clamped, every further add carries again, so acc stays at full scale.
    acc_nxt = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    acc_nxt = sum_ext[ACC_W-1:0];
`endif
  end

  assign accept = in_valid & in_ready;
  assign last   = (cnt == CNT_LAST);
  assign busy   = (state == HOLD) | (cnt != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (clr) begin
            // A beat arriving with clr is handshaken but discarded.
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
          end else if (accept) begin
            if (last) begin
              out_sum   <= acc_nxt;
              out_ovf   <= ovf | carry;
              acc       <= '0;
              cnt       <= '0;
              ovf       <= 1'b0;
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              acc <= acc_nxt;
              cnt <= cnt + 1'b1;
              ovf <= ovf | carry;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= ACC;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ACC;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
